step_scheduler: RTL and testbench

- Sequences the 4-phase stepper drive: issues one-cycle step enables at a programmed rate with a linear acceleration ramp, for a programmed number of steps and a programmed direction.
- Sits between the NIOS-facing register interface and the phase-drive controller.
- step_pulse gates the phase sequencer's advance, and step_dir feeds its direction input.
- Provides a start/busy/done handshake and an abort path.

---
 rtl/step_scheduler.sv | 143 ++++++++++++++
 tb/tb_step_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/step_scheduler.sv
// Stepper step sequencer: linear ramp from START_PERIOD toward target_period, one-cycle step enables.
// Latency: first step_pulse one cycle after start is accepted; start ignored until back in IDLE.
module step_scheduler #(
  parameter int COUNT_W      = 16,
  parameter int PERIOD_W     = 20,
  parameter int START_PERIOD = 120000,
  parameter int RAMP_STEP    = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                dir_in,
  input  logic [COUNT_W-1:0]  step_count,
  input  logic [PERIOD_W-1:0] target_period,
  output logic                step_pulse,
  output logic                step_dir,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [COUNT_W-1:0]  steps_left
);

  localparam logic [PERIOD_W-1:0] START_P = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0] RAMP_P  = PERIOD_W'(RAMP_STEP);
  localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [PERIOD_W-1:0]   timer, timer_nxt;
  logic [PERIOD_W-1:0]   period, period_nxt;
  logic [PERIOD_W-1:0]   target, target_nxt;
  logic                  abort_seen, abort_seen_nxt;
  logic                  step_pulse_nxt, step_dir_nxt, busy_nxt, done_nxt, aborted_nxt;
  logic [COUNT_W-1:0]    steps_left_nxt;

  logic [PERIOD_W-1:0]   tgt_clamp;
  logic [PERIOD_W-1:0]   p_init;
  logic [PERIOD_W:0]     ramp_floor;
  logic [PERIOD_W-1:0]   p_next;

  always_comb begin
    tgt_clamp  = (target_period < MIN_P) ? MIN_P : target_period;
    p_init     = (START_P > tgt_clamp) ? START_P : tgt_clamp;
    // Widened compare so period - RAMP never wraps below the cruise period.
    ramp_floor = {1'b0, target} + {1'b0, RAMP_P};
    p_next     = ({1'b0, period} >= ramp_floor) ? (period - RAMP_P) : target;
  end

  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer;
    period_nxt     = period;
    target_nxt     = target;
    abort_seen_nxt = abort_seen;
    step_pulse_nxt = 1'b0;
    step_dir_nxt   = step_dir;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    aborted_nxt    = aborted;
    steps_left_nxt = steps_left;

    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          step_dir_nxt   = dir_in;
          steps_left_nxt = step_count;
          target_nxt     = tgt_clamp;
          period_nxt     = p_init;
          timer_nxt      = '0;
          aborted_nxt    = 1'b0;
          abort_seen_nxt = 1'b0;
          state_nxt      = (step_count == '0) ? FIN : RUN;
        end
      end

      RUN: begin
        busy_nxt = 1'b1;
        if (abort) begin
          abort_seen_nxt = 1'b1;
          state_nxt      = FIN;
        end else if (timer == '0) begin
          step_pulse_nxt = 1'b1;
          steps_left_nxt = steps_left - COUNT_W'(1);
          // Reload with period-1 so the pulse-to-pulse gap equals the period.
          timer_nxt      = period - PERIOD_W'(1);
          period_nxt     = p_next;
          if (steps_left == COUNT_W'(1)) begin
            state_nxt = FIN;
          end
        end else begin
          timer_nxt = timer - PERIOD_W'(1);
        end
      end

      FIN: begin
        done_nxt    = 1'b1;
        busy_nxt    = 1'b0;
        aborted_nxt = abort_seen;
        state_nxt   = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      period     <= '0;
      target     <= '0;
      abort_seen <= 1'b0;
      step_pulse <= 1'b0;
      step_dir   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      steps_left <= '0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      period     <= period_nxt;
      target     <= target_nxt;
      abort_seen <= abort_seen_nxt;
      step_pulse <= step_pulse_nxt;
      step_dir   <= step_dir_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      aborted    <= aborted_nxt;
      steps_left <= steps_left_nxt;
    end
  end

endmodule

// File: tb/tb_step_scheduler.sv
// Directed bench for step_scheduler with a short ramp (START_PERIOD=10, RAMP_STEP=3).
module tb_step_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, dir_in;
  logic [15:0] step_count;
  logic [19:0] target_period;
  logic        step_pulse, step_dir, busy, done, aborted;
  logic [15:0] steps_left;

  always #5 clk = ~clk;

  step_scheduler #(
    .COUNT_W(16), .PERIOD_W(20), .START_PERIOD(10), .RAMP_STEP(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dir_in(dir_in),
    .step_count(step_count), .target_period(target_period),
    .step_pulse(step_pulse), .step_dir(step_dir), .busy(busy), .done(done),
    .aborted(aborted), .steps_left(steps_left)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int pulse_t[$];
  int pulse_sl[$];
  int done_t, done_cnt, done_busy, done_abt, adj, dir_bad, busy_cycles, last_pulse_busy;
  int snap_sl, snap_busy, snap_dir, snap_pulse, snap_done;
  int fin_sl, fin_dir, fin_abt, fin_busy;

  // Drives one start edge (E0); the sample after it is cycle 0.
  task automatic launch(input logic d, input int cnt, input int tp, input logic ab);
    dir_in        = d;
    step_count    = 16'(cnt);
    target_period = 20'(tp);
    start         = 1'b1;
    abort         = ab;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Observes cycles E0+1..E0+cycles; optional abort/start/reset injected at the given edge.
  task automatic run(input int cycles, input logic exp_dir, input int abort_at,
                     input int start_at, input int rst_at);
    logic prev;
    prev = 1'b0;
    pulse_t.delete();
    pulse_sl.delete();
    done_t = -1; done_cnt = 0; done_busy = -1; done_abt = -1;
    adj = 0; dir_bad = 0; busy_cycles = 0; last_pulse_busy = -1;
    snap_sl = -1; snap_busy = -1; snap_dir = -1; snap_pulse = -1; snap_done = -1;
    for (int n = 1; n <= cycles; n++) begin
      abort = (n == abort_at);
      start = (n == start_at);
      rst_n = !(n == rst_at);
      if (n == start_at) begin
        dir_in        = ~exp_dir;
        step_count    = 16'd9;
        target_period = 20'd50;
      end
      @(posedge clk); #1;
      if (step_pulse) begin
        pulse_t.push_back(n);
        pulse_sl.push_back(int'(steps_left));
        last_pulse_busy = int'(busy);
        if (prev) adj++;
      end
      prev = step_pulse;
      if (busy) busy_cycles++;
      if (busy && step_dir !== exp_dir) dir_bad++;
      if (done) begin
        done_cnt++;
        if (done_t < 0) begin
          done_t    = n;
          done_busy = int'(busy);
          done_abt  = int'(aborted);
        end
      end
      if (n == abort_at || n == rst_at) begin
        snap_sl    = int'(steps_left);
        snap_busy  = int'(busy);
        snap_dir   = int'(step_dir);
        snap_pulse = int'(step_pulse);
        snap_done  = int'(done);
      end
    end
    abort = 1'b0;
    start = 1'b0;
    rst_n = 1'b1;
    fin_sl   = int'(steps_left);
    fin_dir  = int'(step_dir);
    fin_abt  = int'(aborted);
    fin_busy = int'(busy);
  endtask

  task automatic check_pulses(input string tag, input int exp_t[$], input int exp_sl[$]);
    check({tag, "_npulse"}, pulse_t.size(), exp_t.size());
    foreach (exp_t[i]) begin
      check($sformatf("%s_t%0d", tag, i), (i < pulse_t.size()) ? pulse_t[i] : -1, exp_t[i]);
    end
    foreach (exp_sl[i]) begin
      check($sformatf("%s_sl%0d", tag, i), (i < pulse_sl.size()) ? pulse_sl[i] : -1, exp_sl[i]);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; dir_in = 1'b1;
    step_count = 16'd7; target_period = 20'd5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_pulse", int'(step_pulse), 0);
    check("rst_done", int'(done), 0);
    check("rst_aborted", int'(aborted), 0);
    check("rst_dir", int'(step_dir), 0);
    check("rst_steps_left", int'(steps_left), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ramp 10 -> 7 -> 4 (target reached).
    launch(1'b1, 4, 4, 1'b0);
    run(30, 1'b1, 0, 0, 0);
    check_pulses("ramp", '{1, 11, 18, 22}, '{3, 2, 1, 0});
    check("ramp_busy_last_pulse", last_pulse_busy, 1);
    check("ramp_done_t", done_t, 23);
    check("ramp_done_busy", done_busy, 0);
    check("ramp_done_cnt", done_cnt, 1);
    check("ramp_aborted", done_abt, 0);
    check("ramp_dir_bad", dir_bad, 0);
    check("ramp_dir_hold", fin_dir, 1);
    check("ramp_adjacent", adj, 0);

    // Abort on the edge the second pulse is due.
    launch(1'b0, 4, 4, 1'b0);
    run(20, 1'b0, 11, 0, 0);
    check_pulses("abort", '{1}, '{3});
    check("abort_snap_pulse", snap_pulse, 0);
    check("abort_snap_sl", snap_sl, 3);
    check("abort_done_t", done_t, 12);
    check("abort_done_aborted", done_abt, 1);
    check("abort_done_busy", done_busy, 0);
    check("abort_done_cnt", done_cnt, 1);
    check("abort_sl_hold", fin_sl, 3);
    check("abort_flag_hold", fin_abt, 1);
    check("abort_busy_end", fin_busy, 0);

    // Zero-step move; also shows aborted cleared by the new start.
    launch(1'b1, 0, 4, 1'b0);
    run(5, 1'b1, 0, 0, 0);
    check("zero_npulse", pulse_t.size(), 0);
    check("zero_done_t", done_t, 1);
    check("zero_done_busy", done_busy, 0);
    check("zero_aborted", done_abt, 0);
    check("zero_busy_cycles", busy_cycles, 0);
    check("zero_dir", fin_dir, 1);

    // Target above START_PERIOD: constant 20-cycle spacing.
    launch(1'b1, 5, 20, 1'b0);
    run(90, 1'b1, 0, 0, 0);
    check_pulses("cruise", '{1, 21, 41, 61, 81}, '{4, 3, 2, 1, 0});
    check("cruise_done_t", done_t, 82);
    check("cruise_done_cnt", done_cnt, 1);

    // target_period=0 clamps to 2; start and abort together in IDLE.
    launch(1'b0, 6, 0, 1'b1);
    run(35, 1'b0, 0, 0, 0);
    check_pulses("clamp", '{1, 11, 18, 22, 24, 26}, '{5, 4, 3, 2, 1, 0});
    check("clamp_adjacent", adj, 0);
    check("clamp_done_t", done_t, 27);
    check("clamp_aborted", done_abt, 0);
    check("clamp_dir_bad", dir_bad, 0);

    // start mid-move with different inputs is ignored.
    launch(1'b1, 3, 4, 1'b0);
    run(30, 1'b1, 0, 5, 0);
    check_pulses("midstart", '{1, 11, 18}, '{2, 1, 0});
    check("midstart_done_t", done_t, 19);
    check("midstart_done_cnt", done_cnt, 1);
    check("midstart_dir_bad", dir_bad, 0);
    check("midstart_dir_hold", fin_dir, 1);

    // Reset mid-move.
    launch(1'b1, 4, 4, 1'b0);
    run(30, 1'b1, 0, 0, 6);
    check("rstmid_snap_busy", snap_busy, 0);
    check("rstmid_snap_sl", snap_sl, 0);
    check("rstmid_snap_dir", snap_dir, 0);
    check("rstmid_snap_pulse", snap_pulse, 0);
    check("rstmid_snap_done", snap_done, 0);
    check("rstmid_npulse", pulse_t.size(), 1);
    check("rstmid_done_cnt", done_cnt, 0);
    check("rstmid_busy_end", fin_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
